mul_pipe_unit: RTL and testbench
================================

MUL_PIPE_UNIT -- requirements
Module: mul_pipe_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter STAGES, default 3 (legal 1..8), giving the pipeline depth and the accept-to-result latency.
REQ-003 The block SHALL have parameter TAG_W, default 5, giving the width of the opaque tag carried with each op.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an op is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the op is accepted when in_valid && in_ready.
REQ-008 The block SHALL have port funct3, input, 3 bits: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu.
REQ-009 The block SHALL have ports a and b, input, XLEN bits each: the operands.
REQ-010 The block SHALL have port in_tag, input, TAG_W bits: the op identifier.
REQ-011 The block SHALL have port flush, input, 1 bit: discard all in-flight ops.
REQ-012 The block SHALL have port out_valid, output, 1 bit: result holds a completed op.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result when out_valid && out_ready.
REQ-014 The block SHALL have port result, output, XLEN bits: the selected product half.
REQ-015 The block SHALL have port out_tag, output, TAG_W bits: the tag of the op on result.
REQ-016 The block SHALL have port busy, output, 1 bit: at least one stage valid, including the output stage.

Function
REQ-017 Operand extension SHALL be as follows: a is sign-extended for 000/001/010 and zero-extended for 011; b is sign-extended for 000/001 and zero-extended for 010/011; both extend to XLEN+1 bits and the full signed product is 2*XLEN+2 bits.
REQ-018 Result selection SHALL be as follows: 000 -> product[XLEN-1:0]; 001/010/011 -> product[2*XLEN-1:XLEN]; funct3 1xx -> result 0, with the op still completing normally.
REQ-019 Each stage SHALL hold a valid bit plus funct3/tag/partial data, and the last stage drives out_valid/result/out_tag.
REQ-020 Latency SHALL be as follows: an op accepted in cycle N presents out_valid in cycle N+STAGES when no stall occurs.
REQ-021 Throughput SHALL be one op accepted per cycle when out_ready=1 continuously.
REQ-022 Stall SHALL be defined as stall = out_valid && !out_ready, and a stall freezes every stage.
REQ-023 in_ready SHALL equal !stall && !flush.
REQ-024 While stalled, result/out_tag/out_valid SHALL remain stable until taken.
REQ-025 Bubbles SHALL propagate: an empty stage does not block the stages behind it, and a non-accepted cycle inserts valid=0.
REQ-026 On flush, all stage valid bits SHALL clear at the next edge, no op is accepted in the flush cycle, and out_valid=0 the cycle after.
REQ-027 When flush and stall are both active, flush SHALL win.
REQ-028 Data registers SHALL load only when their stage is advancing, and payload values in invalid stages are don't-care except for result.
REQ-029 result SHALL be 0 whenever out_valid=0.

Reset
REQ-030 Reset SHALL clear all stage valid bits, so out_valid=0 and busy=0.
REQ-031 Reset SHALL force result=0 and out_tag=0.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-033 A reset asserted mid-operation SHALL drop all in-flight ops with no output produced, and ops accepted in the reset cycle are discarded.

Structure
REQ-034 Shared package mul_pkg SHALL hold the funct3 enum (MUL, MULH, MULHSU, MULHU) and the XLEN default constant.
REQ-035 Sub-module mul_core SHALL implement the extension and multi-stage product datapath with per-stage enable, while mul_pipe_unit owns the valid/stall/flush control and result selection.

Verification
REQ-036 The bench SHALL check signed low: mul a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB after exactly 3 cycles, tag echoed.
REQ-037 The bench SHALL check the high variants: mulh 0x80000000*0x80000000 -> 0x40000000; mulhsu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; mulhu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-038 The bench SHALL check throughput: 8 back-to-back ops with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles, in order, correct values.
REQ-039 The bench SHALL check backpressure: out_ready=0 for 4 cycles with 3 ops in flight -> in_ready=0, output stable, no loss or duplication; release -> tags drain in order.
REQ-040 The bench SHALL check flush/reset: flush with 2 ops in flight -> no out_valid for them and the next op's result is correct; reset mid-stream -> out_valid=0, result=0, busy=0.
REQ-041 The bench SHALL check the non-mul code: funct3=100 -> out_valid after 3 cycles with result=0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiplier: funct3 op codes and the default width.
package mul_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } funct3_e;

endpackage

// File: rtl/mul_core.sv
// Multiplier datapath: operand extension plus a STAGES-deep shift-and-accumulate
// product pipeline; each stage folds in one CW-bit chunk of b.
module mul_core
  import mul_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int STAGES = 3
) (
  input  logic                clk,
  input  logic [STAGES-1:0]   en,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [2*XLEN-1:0]   product
);

  localparam int PW   = 2*XLEN + 2;
  localparam int CW   = (PW + STAGES - 1) / STAGES;
  localparam int BW   = CW * STAGES;
  localparam int LAST = STAGES - 1;

  logic          a_sgn;
  logic          b_sgn;
  logic [PW-1:0] a_ext;
  logic [BW-1:0] b_ext;

  // b is sign-extended to at least PW bits, so summing its chunks as unsigned
  // digits gives the exact signed product modulo 2^PW.
  always_comb begin
    a_sgn = (funct3 != MULHU);
    b_sgn = (funct3 == MUL) || (funct3 == MULH);
    a_ext = {{(PW-XLEN){a_sgn & a[XLEN-1]}}, a};
    b_ext = {{(BW-XLEN){b_sgn & b[XLEN-1]}}, b};
  end

  logic [PW-1:0] a_q   [STAGES];
  logic [BW-1:0] b_q   [STAGES];
  logic [PW-1:0] acc_q [STAGES];

  logic [PW-1:0] a_src   [STAGES];
  logic [BW-1:0] b_src   [STAGES];
  logic [PW-1:0] acc_src [STAGES];
  logic [PW-1:0] sum     [STAGES];

  always_comb begin
    a_src[0]   = a_ext;
    b_src[0]   = b_ext;
    acc_src[0] = '0;
    for (int i = 1; i < STAGES; i++) begin
      a_src[i]   = a_q[i-1];
      b_src[i]   = b_q[i-1];
      acc_src[i] = acc_q[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      sum[i] = acc_src[i] + a_src[i] * PW'(b_src[i][CW-1:0]);
    end
  end

  // a moves up and b moves down by one chunk per stage, so every stage uses
  // the low chunk of b against the already-shifted a.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (en[i]) begin
        acc_q[i] <= sum[i];
        a_q[i]   <= a_src[i] << CW;
        b_q[i]   <= b_src[i] >> CW;
      end
    end
  end

  assign product = acc_q[LAST][2*XLEN-1:0];

endmodule

// File: rtl/mul_pipe_unit.sv
// Pipelined M-extension multiplier: valid/stall/flush control and result
// selection around the mul_core datapath; STAGES cycles accept-to-result.
module mul_pipe_unit
  import mul_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_nxt;
  logic [STAGES-1:0] en;
  logic [2:0]        f3_q  [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic              stall;
  logic              accept;
  logic [2*XLEN-1:0] product;

  assign out_valid = vld_q[LAST];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall & ~flush;
  assign accept    = in_valid & in_ready;
  assign busy      = |vld_q;

  // A stall freezes the whole pipe; otherwise every valid bit shifts forward
  // and a non-accepted cycle enters as a bubble.
  always_comb begin
    vld_nxt    = vld_q << 1;
    vld_nxt[0] = accept;
    en         = '0;
    en[0]      = accept;
    for (int i = 1; i < STAGES; i++) begin
      en[i] = ~stall & vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q <= vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (en[0]) begin
      f3_q[0]  <= funct3;
      tag_q[0] <= in_tag;
    end
    for (int i = 1; i < STAGES; i++) begin
      if (en[i]) begin
        f3_q[i]  <= f3_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  mul_core #(
    .XLEN   (XLEN),
    .STAGES (STAGES)
  ) u_core (
    .clk     (clk),
    .en      (en),
    .funct3  (funct3),
    .a       (a),
    .b       (b),
    .product (product)
  );

  // Outputs are gated by out_valid so stale payload never leaks out.
  always_comb begin
    result = '0;
    if (out_valid) begin
      case (f3_q[LAST])
        MUL:                 result = product[XLEN-1:0];
        MULH, MULHSU, MULHU: result = product[2*XLEN-1:XLEN];
        default:             result = '0;
      endcase
    end
  end

  assign out_tag = out_valid ? tag_q[LAST] : '0;

endmodule

// File: tb/tb_mul_pipe_unit.sv
// Self-checking bench for mul_pipe_unit: directed vector table, multi-cycle
// handshake sequences, and randomized traffic against a 64-bit arithmetic model.
module tb_mul_pipe_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic        s_ov;
  logic [31:0] s_res;
  logic [4:0]  s_tag;
  logic        s_busy;
  logic        s_irdy;

  mul_pipe_unit #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, ps;
    longint unsigned ux, uy, pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'b000: begin pu = ux * uy; return pu[31:0]; end
      3'b001: begin ps = sx * sy; return ps[63:32]; end
      3'b010: begin ps = sx * longint'(uy); return ps[63:32]; end
      3'b011: begin pu = ux * uy; return pu[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, sample outputs mid-cycle, then cross the edge.
  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [4:0] t, input logic ordy, input logic fl);
    in_valid = v; funct3 = f; a = ia; b = ib; in_tag = t; out_ready = ordy; flush = fl;
    #1;
    s_ov = out_valid; s_res = result; s_tag = out_tag; s_busy = busy; s_irdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, ordy, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  vec_t        vecs [12];
  logic [2:0]  op_f [16];
  logic [31:0] op_a [16];
  logic [31:0] op_b [16];
  int          exp_tag [16];
  exp_t        q [$];

  task automatic make_ops(input int n);
    for (int i = 0; i < n; i++) begin
      op_f[i] = 3'($urandom_range(0, 3));
      op_a[i] = $urandom;
      op_b[i] = $urandom;
    end
  endtask

  // Compare the sampled output against a per-cycle expected tag (-1 = no output).
  task automatic chk_slot(input string name, input int et);
    if (et < 0) begin
      chk({name, "_idle_valid"}, s_ov, 1'b0);
      chk({name, "_idle_result"}, s_res, 32'h0);
    end else begin
      chk({name, "_valid"}, s_ov, 1'b1);
      chk({name, "_tag"}, s_tag, 5'(et));
      chk({name, "_result"}, s_res, ref_mul(op_f[et], op_a[et], op_b[et]));
    end
  endtask

  initial begin
    logic        v, ordy, fl;
    logic [2:0]  f;
    logic [31:0] ra, rb;
    logic [4:0]  t;
    logic        prev_stall;
    logic        prev_fl;
    logic [31:0] prev_res;
    logic [4:0]  prev_tag;
    exp_t        e;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFF};
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE};
    vecs[4]  = '{3'b100, 32'h0000_1234, 32'h0000_5678, 5'd9,  32'h0000_0000};
    vecs[5]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000};
    vecs[6]  = '{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd11, 32'h3FFF_FFFF};
    vecs[7]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000};
    vecs[8]  = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001};
    vecs[9]  = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000};
    vecs[10] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 5'd15, 32'h0000_0001};
    vecs[11] = '{3'b001, 32'h8000_0000, 32'h0000_0001, 5'd16, 32'hFFFF_FFFF};

    reset = 1'b1; in_valid = 1'b0; funct3 = 3'b000; a = '0; b = '0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    idle(1'b1);
    chk("rst_in_ready", s_irdy, 1'b1);
    chk("rst_out_valid", s_ov, 1'b0);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_result", s_res, 32'h0);
    chk("rst_out_tag", s_tag, 5'h0);

    // directed vectors, one op at a time, exact latency
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].tag, 1'b1, 1'b0);
      chk("vec_in_ready", s_irdy, 1'b1);
      idle(1'b1); chk("vec_lat1_valid", s_ov, 1'b0);
      idle(1'b1); chk("vec_lat2_valid", s_ov, 1'b0);
      idle(1'b1);
      chk("vec_valid", s_ov, 1'b1);
      chk("vec_tag", s_tag, vecs[i].tag);
      chk("vec_result", s_res, vecs[i].exp);
      idle(1'b1);
      chk("vec_after_valid", s_ov, 1'b0);
      chk("vec_after_result", s_res, 32'h0);
    end

    // throughput: 8 back-to-back ops, tags 0..7
    make_ops(8);
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        drive(1'b1, op_f[c], op_a[c], op_b[c], 5'(c), 1'b1, 1'b0);
        chk("tput_in_ready", s_irdy, 1'b1);
      end else begin
        idle(1'b1);
      end
      chk_slot("tput", (c >= 3 && c <= 10) ? c - 3 : -1);
    end

    // backpressure: stall 4 cycles with 3 ops in flight, a 4th op waiting
    make_ops(4);
    for (int c = 0; c < 12; c++) exp_tag[c] = -1;
    exp_tag[3] = 0; exp_tag[4] = 0; exp_tag[5] = 0; exp_tag[6] = 0;
    exp_tag[7] = 0; exp_tag[8] = 1; exp_tag[9] = 2; exp_tag[10] = 3;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) drive(1'b1, op_f[c], op_a[c], op_b[c], 5'(c), 1'b1, 1'b0);
      else if (c < 7) drive(1'b1, op_f[3], op_a[3], op_b[3], 5'd3, 1'b0, 1'b0);
      else if (c == 7) drive(1'b1, op_f[3], op_a[3], op_b[3], 5'd3, 1'b1, 1'b0);
      else idle(1'b1);
      chk_slot("bp", exp_tag[c]);
      if (c >= 3 && c < 7) begin
        chk("bp_in_ready_stalled", s_irdy, 1'b0);
        chk("bp_busy", s_busy, 1'b1);
      end
      if (c == 7) chk("bp_in_ready_release", s_irdy, 1'b1);
    end

    // flush with two ops in flight; the flush-cycle op must be refused
    make_ops(3);
    drive(1'b1, op_f[0], op_a[0], op_b[0], 5'd0, 1'b1, 1'b0);
    drive(1'b1, op_f[1], op_a[1], op_b[1], 5'd1, 1'b1, 1'b0);
    drive(1'b1, op_f[2], op_a[2], op_b[2], 5'd9, 1'b1, 1'b1);
    chk("flush_in_ready", s_irdy, 1'b0);
    idle(1'b1);
    chk("flush_busy", s_busy, 1'b0);
    chk_slot("flush_drop", -1);
    for (int c = 0; c < 3; c++) begin
      idle(1'b1);
      chk_slot("flush_drop", -1);
    end
    drive(1'b1, op_f[2], op_a[2], op_b[2], 5'd2, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);
    chk_slot("flush_next", 2);

    // flush during a stall: flush wins
    drive(1'b1, op_f[0], op_a[0], op_b[0], 5'd0, 1'b1, 1'b0);
    idle(1'b1); idle(1'b1);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    chk_slot("flush_stall_pre", 0);
    idle(1'b1);
    chk_slot("flush_stall_post", -1);
    chk("flush_stall_busy", s_busy, 1'b0);

    // reset mid-stream, including an op offered in the reset cycle
    make_ops(3);
    drive(1'b1, op_f[0], op_a[0], op_b[0], 5'd0, 1'b1, 1'b0);
    drive(1'b1, op_f[1], op_a[1], op_b[1], 5'd1, 1'b1, 1'b0);
    reset = 1'b1;
    drive(1'b1, op_f[2], op_a[2], op_b[2], 5'd2, 1'b1, 1'b0);
    reset = 1'b0;
    idle(1'b1);
    chk("mrst_out_valid", s_ov, 1'b0);
    chk("mrst_result", s_res, 32'h0);
    chk("mrst_out_tag", s_tag, 5'h0);
    chk("mrst_busy", s_busy, 1'b0);
    chk("mrst_in_ready", s_irdy, 1'b1);
    for (int c = 0; c < 4; c++) begin
      idle(1'b1);
      chk_slot("mrst_drop", -1);
    end

    // randomized traffic against the queue model
    prev_stall = 1'b0; prev_fl = 1'b0; prev_res = '0; prev_tag = '0;
    for (int c = 0; c < 420; c++) begin
      if (c < 400) begin
        v    = ($urandom_range(0, 99) < 65);
        ordy = ($urandom_range(0, 99) < 70);
        fl   = ($urandom_range(0, 99) < 3);
      end else begin
        v = 1'b0; ordy = 1'b1; fl = 1'b0;
      end
      if (fl) ordy = 1'b0;
      f  = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      t  = 5'($urandom);
      drive(v, f, ra, rb, t, ordy, fl);

      chk("rnd_busy", s_busy, (q.size() != 0));
      chk("rnd_in_ready", s_irdy, !(s_ov && !ordy) && !fl);
      if (prev_stall && !prev_fl) begin
        chk("rnd_stall_valid", s_ov, 1'b1);
        chk("rnd_stall_tag", s_tag, prev_tag);
        chk("rnd_stall_result", s_res, prev_res);
      end
      if (!s_ov) chk("rnd_idle_result", s_res, 32'h0);

      if (fl) begin
        q.delete();
      end else begin
        if (s_ov && ordy) begin
          if (q.size() == 0) begin
            chk("rnd_unexpected_output", 1'b1, 1'b0);
          end else begin
            e = q.pop_front();
            chk("rnd_tag", s_tag, e.tag);
            chk("rnd_result", s_res, e.res);
          end
        end
        if (v && s_irdy) q.push_back('{t, ref_mul(f, ra, rb)});
      end
      prev_stall = s_ov && !ordy;
      prev_fl    = fl;
      prev_res   = s_res;
      prev_tag   = s_tag;
    end
    chk("rnd_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
